// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares the single-port test_memory between the riscV
// instruction-fetch port (IF) and the load/store data port (D).
//
// One access is outstanding at a time. A pending request is granted
// combinationally in an IDLE cycle: the memory strobe, address and write data
// are driven in that same cycle. The access completes exactly MEM_LAT cycles
// later with a one-cycle rvalid pulse on the owning port.
//
// Parameters:
//   AW      memory word-address width driven to test_memory
//   DW      data width
//   MEM_LAT cycles from mem_rden to valid mem_readout (1..7)
//
// Ports:
//   Clk, Reset_n                          clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt              IF read request / grant
//   if_rvalid/if_rdata/if_err             IF completion, data, range error
//   d_req/d_we/d_addr/d_wdata -> d_gnt    data request / grant
//   d_rvalid/d_rdata/d_err                data completion, data, range error
//   mem_address/mem_data/mem_rden/mem_wren  towards test_memory
//   mem_readout                           read data from test_memory
//
// Optional feature (macro MEM_ARB_ROUND_ROBIN_EN): when defined, a tie is
// resolved in favour of the port that did not own the previous access.
// When undefined, D always wins a tie.

module mem_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_rden,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_readout
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_D  = 1'b1;
    localparam logic [2:0] LAT_C  = 3'(MEM_LAT);

    // Any address bit above the memory word-address range marks the access bad.
    function automatic logic addr_oor(input logic [31:0] a);
        return |(a >> AW);
    endfunction

    state_t        state_r, state_nxt_s;
    logic [2:0]    cnt_r;
    logic          owner_r, we_r, oor_r, rdok_r;
    logic [AW-1:0] addr_r;
    logic          if_rvalid_r, d_rvalid_r, if_err_r, d_err_r;
    logic [DW-1:0] if_rdata_r, d_rdata_r, if_rdata_s, d_rdata_s;
    logic          req_any_s, pick_d_s, sel_we_s, sel_oor_s, grant_s;
    logic [31:0]   sel_addr_s;
    logic          done_nxt_s, done_own_s, done_err_s, done_rdok_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_owner_r;
`endif

    // Arbitration: choose the winning port and its access attributes.
    always_comb begin
        req_any_s = if_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d_s  = d_req & (~if_req | (last_owner_r == OWN_IF));
`else
        pick_d_s  = d_req;
`endif
        sel_addr_s = pick_d_s ? d_addr : if_addr;
        sel_we_s   = pick_d_s & d_we;
        sel_oor_s  = addr_oor(sel_addr_s);
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) state_nxt_s = ST_WAIT;
                else         state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_r == LAT_C) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_WAIT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: grant-cycle memory strobes plus the "completes next cycle" decode.
    always_comb begin
        grant_s     = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_data    = {DW{1'b0}};
        mem_address = addr_r;
        done_nxt_s  = 1'b0;
        done_own_s  = owner_r;
        done_err_s  = oor_r;
        done_rdok_s = ~we_r & ~oor_r;
        case (state_r)
            ST_IDLE: begin
                // Reset_n gates the grant so outputs are quiet while reset is held.
                if (req_any_s && Reset_n) begin
                    grant_s     = 1'b1;
                    if_gnt      = ~pick_d_s;
                    d_gnt       = pick_d_s;
                    mem_address = sel_addr_s[AW-1:0];
                    mem_rden    = ~sel_we_s & ~sel_oor_s;
                    mem_wren    = sel_we_s & ~sel_oor_s;
                    mem_data    = sel_we_s ? d_wdata : {DW{1'b0}};
                    done_nxt_s  = (LAT_C == 3'd1);
                    done_own_s  = pick_d_s;
                    done_err_s  = sel_oor_s;
                    done_rdok_s = ~sel_we_s & ~sel_oor_s;
                end else begin
                    grant_s = 1'b0;
                end
            end
            ST_WAIT: begin
                done_nxt_s = ((cnt_r + 3'd1) == LAT_C);
            end
            default: begin
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Latency counter: 1 on the first WAIT cycle, completion when it reaches MEM_LAT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: cnt_r <= grant_s ? 3'd1 : 3'd0;
                ST_WAIT: cnt_r <= (cnt_r == LAT_C) ? 3'd0 : cnt_r + 3'd1;
                default: cnt_r <= 3'd0;
            endcase
        end
    end

    // Access attributes latched in the grant cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_r <= OWN_IF;
            we_r    <= 1'b0;
            oor_r   <= 1'b0;
            addr_r  <= {AW{1'b0}};
        end else if (grant_s) begin
            owner_r <= pick_d_s;
            we_r    <= sel_we_s;
            oor_r   <= sel_oor_s;
            addr_r  <= sel_addr_s[AW-1:0];
        end else begin
            owner_r <= owner_r;
            we_r    <= we_r;
            oor_r   <= oor_r;
            addr_r  <= addr_r;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last owner, starting at IF so that D wins the first tie.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_owner_r <= OWN_IF;
        end else if (grant_s) begin
            last_owner_r <= pick_d_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`endif

    // Completion strobes and error flags, registered one cycle ahead of use.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            rdok_r      <= 1'b0;
            if_err_r    <= 1'b0;
            d_err_r     <= 1'b0;
        end else begin
            if_rvalid_r <= done_nxt_s & (done_own_s == OWN_IF);
            d_rvalid_r  <= done_nxt_s & (done_own_s == OWN_D);
            rdok_r      <= done_nxt_s & done_rdok_s;
            if_err_r    <= (done_nxt_s && done_own_s == OWN_IF) ? done_err_s : if_err_r;
            d_err_r     <= (done_nxt_s && done_own_s == OWN_D)  ? done_err_s : d_err_r;
        end
    end

    // Readout is only valid in the completion cycle, so pass it through then and
    // keep a copy so rdata holds after rvalid drops.
    always_comb begin
        if (if_rvalid_r) if_rdata_s = rdok_r ? mem_readout : {DW{1'b0}};
        else             if_rdata_s = if_rdata_r;
        if (d_rvalid_r)  d_rdata_s  = rdok_r ? mem_readout : {DW{1'b0}};
        else             d_rdata_s  = d_rdata_r;
    end

    // Read-data hold registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            if_rdata_r <= {DW{1'b0}};
            d_rdata_r  <= {DW{1'b0}};
        end else begin
            if_rdata_r <= if_rdata_s;
            d_rdata_r  <= d_rdata_s;
        end
    end

    assign if_rvalid = if_rvalid_r;
    assign d_rvalid  = d_rvalid_r;
    assign if_err    = if_err_r;
    assign d_err     = d_err_r;
    assign if_rdata  = if_rdata_s;
    assign d_rdata   = d_rdata_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with MEM_LAT=1 (scoreboarded, with a
// memory model) and one with MEM_LAT=3 (directed latency and reset checks).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // MEM_LAT = 1 instance
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [9:0]  mem_address;
    logic [31:0] mem_data, mem_readout;
    logic        mem_rden, mem_wren;

    // MEM_LAT = 3 instance
    logic        if_req3, if_gnt3, if_rvalid3, if_err3;
    logic [31:0] if_addr3, if_rdata3;
    logic        d_req3, d_we3, d_gnt3, d_rvalid3, d_err3;
    logic [31:0] d_addr3, d_wdata3, d_rdata3;
    logic [9:0]  mem_address3;
    logic [31:0] mem_data3, mem_readout3;
    logic        mem_rden3, mem_wren3;

    mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1)) dut1 (
        .Clk(clk), .Reset_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_readout(mem_readout)
    );

    mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3)) dut3 (
        .Clk(clk), .Reset_n(rst_n),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
        .if_rdata(if_rdata3), .if_err(if_err3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_gnt(d_gnt3),
        .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_err(d_err3),
        .mem_address(mem_address3), .mem_data(mem_data3), .mem_rden(mem_rden3),
        .mem_wren(mem_wren3), .mem_readout(mem_readout3)
    );

    // Memory model for dut1: one-cycle read latency, word 5 preloaded during reset.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (!rst_n) mem[10'h005] <= 32'h00C0FFEE;
        else if (mem_wren) mem[mem_address] <= mem_data;
        mem_readout <= mem_rden ? mem[mem_address] : 32'hBAD0BAD0;
    end

    // Memory model for dut3: three-stage read pipeline returning a fixed word.
    logic [31:0] p3 [0:2];
    always @(posedge clk) begin
        p3[0] <= mem_rden3 ? 32'h12345678 : 32'hBAD0BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_readout3 = p3[2];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for dut1 completions.
    always @(negedge clk) begin
        if (rst_n && (if_rvalid || d_rvalid)) begin
            if (sb.size() == 0) begin
                check("sb_extra_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_both_rvalid", 32'(if_rvalid & d_rvalid), 32'd0);
                check("sb_port", 32'(d_rvalid), 32'(mon_e.is_d));
                check("sb_rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
                check("sb_err", 32'(mon_e.is_d ? d_err : if_err), 32'(mon_e.err));
            end
        end
    end

    // One complete access on dut1; entered and left just after a rising edge.
    task automatic acc1(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
        exp_t e;
        logic in_rng;
        in_rng = ((addr >> 10) == 32'd0);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        e.is_d = is_d; e.rdata = exp_rdata; e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        check("gnt_if", 32'(if_gnt), 32'(!is_d));
        check("gnt_d", 32'(d_gnt), 32'(is_d));
        check("mem_rden", 32'(mem_rden), 32'(in_rng & !we));
        check("mem_wren", 32'(mem_wren), 32'(in_rng & we));
        check("mem_address", 32'(mem_address), 32'(addr[9:0]));
        check("mem_data", mem_data, (is_d && we) ? wdata : 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("rvalid", 32'(is_d ? d_rvalid : if_rvalid), 32'd1);
        check("rden_wait", 32'(mem_rden | mem_wren), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic exp_d;
        exp_t e;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        if_req3 = 1'b0; if_addr3 = 32'd0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = 32'd0; d_wdata3 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'({if_gnt, d_gnt}), 32'd0);
        check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
        check("rst_err", 32'({if_err, d_err}), 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        check("rst_mem", 32'({mem_rden, mem_wren, mem_address}) | mem_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IF read of word 5.
        acc1(1'b0, 1'b0, 32'h5, 32'd0, 32'h00C0FFEE, 1'b0);

        // Tie: both requests held for four accesses.
        if_req = 1'b1; if_addr = 32'h5; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            @(negedge clk);
            check("tie_gnt_d", 32'(d_gnt), 32'(exp_d));
            check("tie_gnt_if", 32'(if_gnt), 32'(!exp_d));
            e.is_d = exp_d; e.rdata = 32'h00C0FFEE; e.err = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            if (i == 3) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clk);
            check("tie_wait_nognt", 32'({if_gnt, d_gnt}), 32'd0);
            @(posedge clk); #1;
        end

        // D write then read-back of the top word.
        acc1(1'b1, 1'b1, 32'h3FF, 32'hDEADBEEF, 32'd0, 1'b0);
        acc1(1'b1, 1'b0, 32'h3FF, 32'd0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("hold_rvalid", 32'(d_rvalid), 32'd0);
        check("hold_rdata", d_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Out-of-range data read.
        acc1(1'b1, 1'b0, 32'h400, 32'd0, 32'd0, 1'b0 | 1'b1);
        @(negedge clk);
        check("oor_err_hold", 32'(d_err), 32'd1);
        @(posedge clk); #1;

        // MEM_LAT=3: D request raised during the IF access waits for completion.
        if_req3 = 1'b1; if_addr3 = 32'h7;
        @(negedge clk);
        check("l3_if_gnt", 32'(if_gnt3), 32'd1);
        check("l3_rden", 32'(mem_rden3), 32'd1);
        @(posedge clk); #1;
        if_req3 = 1'b0; d_req3 = 1'b1; d_addr3 = 32'h9;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("l3_wait_no_dgnt", 32'(d_gnt3), 32'd0);
            check("l3_if_rvalid", 32'(if_rvalid3), 32'(k == 3));
            check("l3_wait_addr", 32'(mem_address3), 32'h7);
            check("l3_wait_rden", 32'(mem_rden3), 32'd0);
            if (k == 3) check("l3_if_rdata", if_rdata3, 32'h12345678);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("l3_d_gnt", 32'(d_gnt3), 32'd1);
        check("l3_if_rvalid_drop", 32'(if_rvalid3), 32'd0);
        check("l3_if_rdata_hold", if_rdata3, 32'h12345678);
        @(posedge clk); #1;
        d_req3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("l3_d_rvalid", 32'(d_rvalid3), 32'(k == 3));
            if (k == 3) check("l3_d_rdata", d_rdata3, 32'h12345678);
            @(posedge clk); #1;
        end

        // Reset pulsed in the WAIT state of a MEM_LAT=3 access.
        if_req3 = 1'b1; if_addr3 = 32'h7;
        @(negedge clk);
        check("rw_gnt", 32'(if_gnt3), 32'd1);
        @(posedge clk); #1;
        if_req3 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("rw_gnt0", 32'({if_gnt3, d_gnt3}), 32'd0);
        check("rw_rvalid0", 32'({if_rvalid3, d_rvalid3}), 32'd0);
        check("rw_err0", 32'({if_err3, d_err3}), 32'd0);
        check("rw_if_rdata0", if_rdata3, 32'd0);
        check("rw_d_rdata0", d_rdata3, 32'd0);
        check("rw_mem0", 32'({mem_rden3, mem_wren3, mem_address3}) | mem_data3, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; if_req3 = 1'b1; if_addr3 = 32'h8;
        @(negedge clk);
        check("rw_regnt", 32'(if_gnt3), 32'd1);
        check("rw_mem_addr", 32'(mem_address3), 32'h8);
        @(posedge clk); #1;
        if_req3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("rw_if_rvalid", 32'(if_rvalid3), 32'(k == 3));
            check("rw_d_rvalid", 32'(d_rvalid3), 32'd0);
            @(posedge clk); #1;
        end

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
